// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_addsub_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_addsub_fa.sv
// One-bit full adder; purely combinational, no latency, no flow control.
module Full_Adder (
   input  logic A,
   input  logic B,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = A ^ B ^ cin;
   assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first; done pulses WIDTH+1 cycles after the start cycle.
// start is taken only while ready (IDLE or DONE); it is ignored while busy.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zf,
   output logic             sf,
   output logic             vf
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             msb_cin_q, msb_cin_d;
   logic             cout_q, cout_d;
   logic             zf_q, zf_d;
   logic             sf_q, sf_d;
   logic             vf_q, vf_d;
   logic             fa_sum, fa_cout;
   logic             accept, last_bit;

   Full_Adder u_fa (
      .A    (a_sh_q[0]),
      .B    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign accept   = start && ready;
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   assign result = res_q;
   assign cout   = cout_q;
   assign zf     = zf_q;
   assign sf     = sf_q;
   assign vf     = vf_q;

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      msb_cin_d = msb_cin_q;
      cout_d    = cout_q;
      zf_d      = zf_q;
      sf_d      = sf_q;
      vf_d      = vf_q;

      if (accept) begin
         // Subtraction is A + ~B + 1: invert B and seed the carry with op_sub.
         state_d = ST_RUN;
         a_sh_d  = a;
         b_sh_d  = b ^ {WIDTH{op_sub}};
         carry_d = op_sub;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               a_sh_d  = a_sh_q >> 1;
               b_sh_d  = b_sh_q >> 1;
               res_d   = {fa_sum, res_q[WIDTH-1:1]};
               carry_d = fa_cout;
               cnt_d   = cnt_q + CW'(1);
               if (last_bit) begin
                  // Flags are latched here so they stay stable until the next start.
                  state_d   = ST_DONE;
                  msb_cin_d = carry_q;
                  cout_d    = fa_cout;
                  vf_d      = carry_q ^ fa_cout;
                  sf_d      = fa_sum;
                  zf_d      = (res_d == '0);
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         msb_cin_q <= 1'b0;
         cout_q    <= 1'b0;
         zf_q      <= 1'b0;
         sf_q      <= 1'b0;
         vf_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         res_q     <= res_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         msb_cin_q <= msb_cin_d;
         cout_q    <= cout_d;
         zf_q      <= zf_d;
         sf_q      <= sf_d;
         vf_q      <= vf_d;
      end
   end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled only when ready=1.
REQ-006 op_sub  input  1  0 = A+B, 1 = A-B; captured with start.
REQ-007 a  input  WIDTH  operand A; captured with start.
REQ-008 b  input  WIDTH  operand B; captured with start.
REQ-009 ready  output  1  high in IDLE and DONE; block can accept start.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  single-cycle pulse; result and flags are valid.
REQ-012 result  output  WIDTH  sum/difference.
REQ-013 cout  output  1  final carry out (subtract: 1 = no borrow).
REQ-014 zf, sf, vf  output  1 each  zero, sign (result MSB) and signed overflow flags.

Function
REQ-015 FSM SHALL have the states IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE after WIDTH bit-cycles.
- DONE -> RUN on start, else -> IDLE.
REQ-016 On an accepted start, the block SHALL:
- load the A shift register with a;
- load the B shift register with b XOR {WIDTH{op_sub}};
- load the carry flip-flop with op_sub;
- clear the bit counter (width clog2(WIDTH)+1).
REQ-017 Each RUN cycle SHALL add one bit using the full-adder sub-module:
- full-adder inputs: A[0], B[0], carry flip-flop.
- A and B shift right by one.
- The sum bit shifts into the result register MSB; the result register shifts right.
- The carry flip-flop takes the full-adder cout.
- The counter increments.
REQ-018 On the last bit-cycle (counter = WIDTH-1), the block SHALL save the carry-in of that bit as msb_cin.
REQ-019 Latency: start is accepted at rising edge E; done SHALL be high during the cycle after edge E+WIDTH, i.e. exactly WIDTH+1 cycles after acceptance.
REQ-020 In DONE, outputs SHALL be:
- cout = carry flip-flop;
- vf = msb_cin XOR cout;
- sf = result[WIDTH-1];
- zf = (result == 0).
REQ-021 result and flags SHALL hold their values from DONE until the next accepted start.
REQ-022 During RUN, result and flags SHALL NOT be treated as valid; the bench checks them only at done or later.
REQ-023 start asserted while busy=1 SHALL be ignored, with no effect on operands or timing.
REQ-024 start in the DONE cycle SHALL be accepted (back-to-back operation):
- done still pulses in that cycle;
- the next done follows WIDTH+1 cycles later.
REQ-025 Changes on a, b or op_sub after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-026 While rst_n=0, the block SHALL force:
- state = IDLE, ready = 1, busy = 0, done = 0;
- result = 0, cout = 0, zf = 0, sf = 0, vf = 0;
- shift registers, counter, carry flip-flop and msb_cin = 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation immediately, with no done pulse.
- The first start after rst_n rises is accepted normally.

Structure
REQ-028 FSM state encodings and the default WIDTH SHALL live in the shared project package/header.
REQ-029 Exactly one sub-module, Full_Adder (A, B, cin -> sum, cout), SHALL be instantiated once as the bit-serial datapath.

Verification (WIDTH=32)
REQ-030 a=5, b=3, op_sub=0 -> result=8, cout=0, zf=0, sf=0, vf=0; done exactly 33 cycles after acceptance.
REQ-031 Add cases:
- a=0xFFFFFFFF, b=1, add -> result=0, cout=1, zf=1, vf=0.
- a=0x7FFFFFFF, b=1, add -> result=0x80000000, sf=1, vf=1, cout=0.
REQ-032 Subtract cases:
- a=3, b=5 -> result=0xFFFFFFFE, cout=0, sf=1.
- a=5, b=5 -> result=0, zf=1, cout=1.
- a=0x80000000, b=1 -> result=0x7FFFFFFF, vf=1.
REQ-033 Start/operand robustness: start a=10, b=20; at cycle 5 pulse start with a=1, b=1 and change the inputs -> result=30, and exactly one done.
- Then assert start during the done cycle with a=1, b=2 -> second done 33 cycles later with result=3.
REQ-034 Reset mid-operation: assert rst_n=0 after 10 RUN cycles -> immediately result=0, busy=0, ready=1, and no done pulse.
- Release reset, then 7+9 -> result=16.
